hcu_digest_out: RTL
===================

# hcu_digest_out

Output serializer for the hash computation unit. It captures the eight final hash words in the shared 64-bit lane format. In SHA-512 mode it uses the full lane; in SHA-256 mode the 32-bit value sits in bits [63:32] and bits [31:0] are don't-care. It emits the digest as a ready/valid stream of 32-bit words with a last-word marker. It sits between the HCU hash registers and the host-side output FIFO/DMA, and is the consumer/unpacker of the dual-mode word format produced by the HCU adders.

## Interface
Parameters:
- NUM_WORDS, 8, number of hash words captured (H0..H7); the block is only specified and verified for 8.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode64  in  1  1 = SHA-512 (full 64-bit lanes), 0 = SHA-256 (32-bit value in lane bits [63:32]); sampled only at capture.
- digest_in  in  512  H0 at [511:448], H1 at [447:384], …, H7 at [63:0].
- digest_valid  in  1  digest_in/mode64 valid for capture.
- digest_ready  out  1  block idle and able to capture; equals (state == IDLE).
- m_tdata  out  32  output word.
- m_tvalid  out  1  m_tdata valid.
- m_tready  in  1  downstream accepts word.
- m_tlast  out  1  marks the final word of a digest.
- busy  out  1  high while in SEND.

## Operation
- Two states: IDLE and SEND.
- In IDLE, digest_ready = 1.
- Capture happens when digest_valid && digest_ready:
  - register digest_in into a 512-bit shadow;
  - latch mode64 into mode_q;
  - clear the word index idx;
  - go to SEND.
- Word count:
  - mode_q = 1: 16 words;
  - mode_q = 0: 8 words.
- Word order, mode_q = 1: H0[63:32], H0[31:0], H1[63:32], H1[31:0], …, H7[31:0]; idx k selects H(k>>1), with the upper half when k is even.
- Word order, mode_q = 0: H0[63:32], H1[63:32], …, H7[63:32]; idx k selects Hk[63:32]. Lower halves are never emitted.
- In SEND, m_tvalid = 1 and m_tdata = the selected word.
- A transfer is m_tvalid && m_tready. Each transfer increments idx.
- m_tlast = 1 exactly when idx = count−1 (15 or 7) and m_tvalid = 1.
- Transfer with m_tlast returns the block to IDLE.
- m_tdata, m_tlast and m_tvalid stay stable while m_tvalid && !m_tready; no word is ever dropped or duplicated.
- Input changes after capture (digest_in, mode64) have no effect on the frame in flight.
- digest_valid while busy is ignored; digest_ready is low, and the upstream holds.
- idx is 4 bits and never wraps within a frame. Terminal values are 15 (mode 1) and 7 (mode 0).
- Reset, including mid-frame, aborts the frame immediately:
  - state = IDLE, idx = 0, mode_q = 0, shadow = 0;
  - m_tvalid = 0, m_tlast = 0, m_tdata = 0, busy = 0, digest_ready = 1.
- No partial frame resumes after reset.

## Timing
- Capture at rising edge N, giving m_tvalid = 1 and word 0 on m_tdata after edge N; the first transfer can occur at edge N+1.
- Throughput is one word per cycle while m_tready = 1.
- With m_tready held high:
  - mode64 frame: transfers at edges N+1..N+16; digest_ready = 1 after edge N+16; next capture earliest at N+17;
  - SHA-256 frame: transfers at edges N+1..N+8; digest_ready = 1 after N+8.
- There is no same-edge capture on the last transfer. One idle cycle between frames is required and accepted.
- digest_ready and busy are registered-state decodes with no combinational path from m_tready. m_tdata may be a mux of registered state.

## Test plan
- Reset, then mode64 = 1, H_i = {32'h1000_0000+2i, 32'h1000_0000+2i+1}, m_tready = 1 → 16 words 0x10000000..0x1000000F in order. m_tlast appears only on 0x1000000F. digest_ready stays low for 16 cycles, then is 1.
- mode64 = 0, H_i[63:32] = 0x6A09E667+i, lower halves = 0xDEADBEEF → exactly 8 words 0x6A09E667..0x6A09E66E. No 0xDEADBEEF is emitted. m_tlast is on the 8th word.
- mode64 = 1 with m_tready toggled pseudo-randomly (including stalls of 3 cycles on the last word) → the same 16-word sequence. m_tdata and m_tlast are stable during every stall. Transfer count is 16.
- During SEND: change digest_in, toggle mode64, and pulse digest_valid → output is unchanged and no second capture occurs. After the frame, the held digest_valid is captured one cycle after digest_ready rises.
- Assert rst_n = 0 after 5 transfers of a mode64 frame → m_tvalid, m_tlast and busy drop asynchronously and digest_ready = 1. A new SHA-256 capture then emits a clean 8-word frame starting at its H0.
- Back-to-back mode64 frame then SHA-256 frame with digest_valid held high → 16 words, 1 idle cycle, 8 words, each with correct m_tlast placement.

Source files
------------

// File: rtl/hcu_digest_out.sv
// hcu_digest_out
// Output serializer for the hash computation unit. It captures the eight
// final hash words in the shared 64-bit lane format and streams them out as
// 32-bit words over a ready/valid interface. The last word of a digest is
// marked with m_tlast.
//   SHA-512 (mode64=1): 16 words, H0[63:32], H0[31:0], ..., H7[31:0]
//   SHA-256 (mode64=0): 8 words,  H0[63:32], H1[63:32], ..., H7[63:32]
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   mode64         lane format select, sampled only at capture
//   digest_in      H0 at [511:448] ... H7 at [63:0]
//   digest_valid   digest_in/mode64 offered for capture
//   digest_ready   idle and able to capture
//   m_tdata/m_tvalid/m_tready/m_tlast   output word stream
//   busy           frame in flight
module hcu_digest_out #(
    parameter int NUM_WORDS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode64,
    input  logic [NUM_WORDS*64-1:0] digest_in,
    input  logic                    digest_valid,
    output logic                    digest_ready,
    output logic [31:0]             m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic                    busy
);

    localparam int IDX_W = $clog2(2 * NUM_WORDS);

    localparam logic [IDX_W-1:0] LAST_64 = IDX_W'(2 * NUM_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_32 = IDX_W'(NUM_WORDS - 1);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_mode;
    logic [NUM_WORDS*64-1:0] r_shadow;

    logic [IDX_W-1:0]        w_pos;
    logic [IDX_W+4:0]        w_base;
    logic                    w_last;
    logic                    w_send;

    assign w_send = (r_state == S_SEND);

    // The shadow is viewed as 2*NUM_WORDS 32-bit slots, slot 0 at the top.
    // SHA-512 walks every slot; SHA-256 visits only the even (upper-half)
    // slots, so the slot number is simply idx doubled.
    assign w_pos  = r_mode ? r_idx : {r_idx[IDX_W-2:0], 1'b0};
    // Bit offset of slot p is 32*(2*NUM_WORDS-1-p); for a power-of-two slot
    // count the subtraction is a bitwise inversion.
    assign w_base = {~w_pos, 5'b0_0000};
    assign w_last = r_mode ? (r_idx == LAST_64) : (r_idx == LAST_32);

    assign digest_ready = (r_state == S_IDLE);
    assign busy         = w_send;
    assign m_tvalid     = w_send;
    assign m_tlast      = w_send & w_last;
    assign m_tdata      = w_send ? r_shadow[w_base +: 32] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_mode   <= 1'b0;
            r_shadow <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (digest_valid) begin
                        r_shadow <= digest_in;
                        r_mode   <= mode64;
                        r_idx    <= '0;
                        r_state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (m_tready) begin
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
